match_ctrl: RTL and testbench
=============================

// Module: match_ctrl
// PURPOSE
//  Parametrised match controller: next generation of the single-match scorer. Owns scoring,
//  serve/game-over freeze timing and rally speed-up; drives ball speed, ball_reset and serve side
//  to the ball engine. Adds configurable win score, optional win-by-two, per-rally speed ramp and
//  serve direction. Runs on the 1 kHz game clock (1 tick = 1 ms).
// PARAMETERS
//  SCORE_W       4      score counter width
//  WIN_SCORE     9      points needed to win (must be <= 2**SCORE_W-1)
//  WIN_BY_TWO    0      1: winner must also lead by >=2 (capped, see BEHAVIOUR)
//  FREEZE_W      14     freeze counter width
//  SERVE_TICKS   2000   freeze after a point
//  OVER_TICKS    16383  freeze after reset and after game over
//  SPEED_W       5      signed speed width
//  SPEED_BASE    11     speed at serve
//  SPEED_MAX     15     speed ceiling
//  HITS_PER_STEP 4      paddle hits per +1 speed step (>=1)
// PORTS
//  game_clk    in   1          1 kHz game clock
//  reset_n     in   1          asynchronous active-low reset
//  start       in   1          debounced start; cuts freeze short
//  out_left    in   1          ball left the field on the left: credit score_p1
//  out_right   in   1          ball left the field on the right: credit score_p2
//  paddle_hit  in   1          one-cycle pulse per paddle bounce
//  speed       out  SPEED_W    signed ball speed; 0 = ball frozen
//  ball_reset  out  1          one-cycle pulse: re-centre ball
//  serve_dir   out  1          0 = serve toward left, 1 = toward right
//  score_p1    out  SCORE_W    player 1 score
//  score_p2    out  SCORE_W    player 2 score
//  game_over   out  1          high from winning point until the next game starts
//  winner      out  1          0 = p1, 1 = p2; valid while game_over
// BEHAVIOUR
//  Reset (async, reset_n=0): state FREEZE, freeze=OVER_TICKS, scores 0, speed 0, ball_reset 1,
//   serve_dir 0, game_over 0, winner 0, hit counter 0. All outputs registered.
//  FREEZE: speed 0; freeze <= start ? 1 : freeze-1; ball_reset <= (freeze==1).
//   At freeze==1, if game_over: scores <= 0 and game_over <= 0 on that edge.
//   At freeze==0: -> PLAY; speed <= SPEED_BASE; hit counter <= 0. The ball_reset pulse coincides
//   with this PLAY-entry cycle.
//  PLAY: ball_reset 0; start ignored.
//   Priority per cycle: out_left > out_right > paddle_hit (lower-priority events same cycle dropped).
//   Point: scorer +1; speed <= 0; hit counter 0; serve_dir <= side that conceded
//    (out_left -> 0, out_right -> 1); -> FREEZE.
//   Win check on the post-increment score n vs opponent m: n >= WIN_SCORE and
//    (WIN_BY_TWO==0 or n-m >= 2), or n == 2**SCORE_W-1 (saturation cap, always wins).
//    On win: game_over 1, winner = scorer, freeze = OVER_TICKS; else freeze = SERVE_TICKS.
//   paddle_hit: counter +1; on the HITS_PER_STEP-th hit counter -> 0,
//    speed <= min(speed+1, SPEED_MAX). Speed never decreases within a rally.
//  Scores never wrap; a score never increments while in FREEZE.
//  Reset mid-rally or mid-freeze: immediate return to reset values.
// TESTING
//  1 Reset, hold start=0 -> ball_reset 1, speed 0 for OVER_TICKS+1 cycles; then ball_reset pulse,
//    speed=11.
//  2 In PLAY, pulse out_left -> score_p1=1, speed 0, serve_dir 0; 2000 cycles later ball_reset pulse,
//    speed 11.
//  3 In FREEZE, assert start -> freeze jumps to 1; PLAY with speed 11 within 2 cycles.
//  4 In PLAY, 9 paddle_hit pulses -> speed 11,...,13; with SPEED_MAX=12, capped at 12;
//    next point -> speed 0.
//  5 WIN_BY_TWO=0, p1 at 8 -> out_left gives 9, game_over=1, winner=0; at end of freeze scores 0,
//    game_over 0.
//  6 WIN_BY_TWO=1, 9:9 -> p1 point: 10:9, no win; p1 point: 11:9 -> game_over.
//    Same cycle out_left+out_right -> only p1 credited.

Source files
------------

// File: rtl/match_ctrl_if.sv
// Match controller bus: the game-side inputs the scorer consumes and the
// ball-engine / display outputs it drives. The controller uses the slave
// modport; the environment (ball engine, buttons, display) uses master.
`timescale 1ns/1ps
interface match_ctrl_if #(
    parameter int SCORE_W = 4,
    parameter int SPEED_W = 5
);
    logic                      start;
    logic                      out_left;
    logic                      out_right;
    logic                      paddle_hit;
    logic signed [SPEED_W-1:0] speed;
    logic                      ball_reset;
    logic                      serve_dir;
    logic [SCORE_W-1:0]        score_p1;
    logic [SCORE_W-1:0]        score_p2;
    logic                      game_over;
    logic                      winner;

    modport master (
        output start, out_left, out_right, paddle_hit,
        input  speed, ball_reset, serve_dir, score_p1, score_p2, game_over, winner
    );

    modport slave (
        input  start, out_left, out_right, paddle_hit,
        output speed, ball_reset, serve_dir, score_p1, score_p2, game_over, winner
    );
endinterface

// File: rtl/match_ctrl.sv
// Match controller: keeps score, times the serve and game-over freezes and
// ramps the ball speed during a rally. One tick of game_clk is 1 ms.
`timescale 1ns/1ps
module match_ctrl #(
    parameter int SCORE_W       = 4,
    parameter int WIN_SCORE     = 9,
    parameter int WIN_BY_TWO    = 0,
    parameter int FREEZE_W      = 14,
    parameter int SERVE_TICKS   = 2000,
    parameter int OVER_TICKS    = 16383,
    parameter int SPEED_W       = 5,
    parameter int SPEED_BASE    = 11,
    parameter int SPEED_MAX     = 15,
    parameter int HITS_PER_STEP = 4
) (
    input  logic         game_clk,
    input  logic         reset_n,
    match_ctrl_if.slave  bus
);

    localparam int HIT_W = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP + 1) : 1;

    localparam logic [SCORE_W-1:0]        SCORE_CAP = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0]        WIN_N     = SCORE_W'(WIN_SCORE);
    localparam logic [FREEZE_W-1:0]       FZ_OVER   = FREEZE_W'(OVER_TICKS);
    localparam logic [FREEZE_W-1:0]       FZ_SERVE  = FREEZE_W'(SERVE_TICKS);
    localparam logic [FREEZE_W-1:0]       FZ_ONE    = FREEZE_W'(1);
    localparam logic signed [SPEED_W-1:0] SPD_BASE  = SPEED_W'(SPEED_BASE);
    localparam logic signed [SPEED_W-1:0] SPD_MAX   = SPEED_W'(SPEED_MAX);
    localparam logic [HIT_W-1:0]          HIT_LAST  = HIT_W'(HITS_PER_STEP);
    localparam logic [HIT_W-1:0]          HIT_ONE   = HIT_W'(1);

    typedef enum logic [0:0] {
        ST_FREEZE = 1'b0,
        ST_PLAY   = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [FREEZE_W-1:0]       freeze_q, freeze_d;
    logic [SCORE_W-1:0]        score1_q, score1_d;
    logic [SCORE_W-1:0]        score2_q, score2_d;
    logic signed [SPEED_W-1:0] speed_q, speed_d;
    logic [HIT_W-1:0]          hits_q, hits_d;
    logic                      ball_reset_q, ball_reset_d;
    logic                      serve_dir_q, serve_dir_d;
    logic                      game_over_q, game_over_d;
    logic                      winner_q, winner_d;

    // Point bookkeeping shared by both scoring directions.
    logic                      pt_who;
    logic [SCORE_W-1:0]        pt_n;
    logic [SCORE_W-1:0]        pt_m;
    logic [HIT_W-1:0]          hits_inc;

    // Score increment that sticks at the counter ceiling instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_CAP) ? s : s + SCORE_W'(1);
    endfunction

    // One speed step, clamped to the ceiling so a long rally never overflows.
    function automatic logic signed [SPEED_W-1:0] speed_step(input logic signed [SPEED_W-1:0] v);
        return (v >= SPD_MAX) ? SPD_MAX : v + SPEED_W'(1);
    endfunction

    // Win rule on the scorer's new score n against the opponent's m. Reaching
    // the counter ceiling always ends the game so a deuce battle cannot
    // saturate both scores forever.
    function automatic logic is_win(input logic [SCORE_W-1:0] n, input logic [SCORE_W-1:0] m);
        logic [SCORE_W:0] n_x;
        logic [SCORE_W:0] m_x;
        logic             lead_ok;
        n_x     = {1'b0, n};
        m_x     = {1'b0, m};
        lead_ok = (WIN_BY_TWO == 0) || (n_x >= m_x + (SCORE_W+1)'(2));
        return (n == SCORE_CAP) || ((n >= WIN_N) && lead_ok);
    endfunction

    // Next-state and next-output logic for the freeze / play sequencing.
    always_comb begin
        state_d      = state_q;
        freeze_d     = freeze_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        speed_d      = speed_q;
        hits_d       = hits_q;
        ball_reset_d = 1'b0;
        serve_dir_d  = serve_dir_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;

        // out_left wins over out_right when both arrive together.
        pt_who   = bus.out_left ? 1'b0 : 1'b1;
        pt_n     = pt_who ? score_inc(score2_q) : score_inc(score1_q);
        pt_m     = pt_who ? score1_q : score2_q;
        hits_inc = hits_q + HIT_ONE;

        case (state_q)
            ST_FREEZE: begin
                speed_d = '0;
                if (freeze_q == '0) begin
                    state_d = ST_PLAY;
                    speed_d = SPD_BASE;
                    hits_d  = '0;
                end else begin
                    // The re-centre pulse lands on the last frozen cycle.
                    ball_reset_d = (freeze_q == FZ_ONE);
                    freeze_d     = bus.start ? FZ_ONE : freeze_q - FZ_ONE;
                    if ((freeze_q == FZ_ONE) && game_over_q) begin
                        score1_d    = '0;
                        score2_d    = '0;
                        game_over_d = 1'b0;
                    end
                end
            end
            ST_PLAY: begin
                if (bus.out_left || bus.out_right) begin
                    if (pt_who) begin
                        score2_d = pt_n;
                    end else begin
                        score1_d = pt_n;
                    end
                    serve_dir_d = pt_who;
                    speed_d     = '0;
                    hits_d      = '0;
                    state_d     = ST_FREEZE;
                    if (is_win(pt_n, pt_m)) begin
                        game_over_d = 1'b1;
                        winner_d    = pt_who;
                        freeze_d    = FZ_OVER;
                    end else begin
                        freeze_d    = FZ_SERVE;
                    end
                end else if (bus.paddle_hit) begin
                    if (hits_inc == HIT_LAST) begin
                        hits_d  = '0;
                        speed_d = speed_step(speed_q);
                    end else begin
                        hits_d  = hits_inc;
                    end
                end
            end
            default: begin
                state_d = ST_FREEZE;
            end
        endcase
    end

    // State and output registers; reset parks the match in the long freeze.
    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_FREEZE;
            freeze_q     <= FZ_OVER;
            score1_q     <= '0;
            score2_q     <= '0;
            speed_q      <= '0;
            hits_q       <= '0;
            ball_reset_q <= 1'b1;
            serve_dir_q  <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            freeze_q     <= freeze_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            speed_q      <= speed_d;
            hits_q       <= hits_d;
            ball_reset_q <= ball_reset_d;
            serve_dir_q  <= serve_dir_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    assign bus.speed      = speed_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.score_p1   = score1_q;
    assign bus.score_p2   = score2_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: two instances (default rules, and win-by-two with a
// low speed ceiling and short freezes) checked against a rule-level model.
`timescale 1ns/1ps
module tb_match_ctrl;

    localparam int SW      = 4;
    localparam int PW      = 5;
    localparam int A_SERVE = 2000;
    localparam int A_OVER  = 16383;
    localparam int B_SERVE = 30;
    localparam int B_OVER  = 50;
    localparam int B_MAX   = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    match_ctrl_if #(.SCORE_W(SW), .SPEED_W(PW)) ifa();
    match_ctrl_if #(.SCORE_W(SW), .SPEED_W(PW)) ifb();

    match_ctrl #(.SCORE_W(SW), .SPEED_W(PW), .WIN_BY_TWO(0)) dut_a (
        .game_clk(clk), .reset_n(rst_n), .bus(ifa));

    match_ctrl #(.SCORE_W(SW), .SPEED_W(PW), .WIN_BY_TWO(1), .SERVE_TICKS(B_SERVE),
                 .OVER_TICKS(B_OVER), .SPEED_MAX(B_MAX)) dut_b (
        .game_clk(clk), .reset_n(rst_n), .bus(ifb));

    int n_err = 0;
    int n_chk = 0;
    bit mon_en = 1'b0;

    // ---------------- reference model ----------------
    typedef struct packed {
        int win_score; int wb2; int serve; int over; int base; int smax; int hps; int cap;
    } cfg_t;

    typedef struct packed {
        bit play; int fz; int p1; int p2; int spd; int hits; bit brst; bit sdir; bit go; bit win;
    } mdl_t;

    cfg_t cfg_a = '{9, 0, A_SERVE, A_OVER, 11, 15, 4, 15};
    cfg_t cfg_b = '{9, 1, B_SERVE, B_OVER, 11, B_MAX, 4, 15};
    mdl_t ma, mb;

    function automatic mdl_t m_reset(input cfg_t c);
        mdl_t r;
        r = '0;
        r.fz = c.over;
        r.brst = 1'b1;
        return r;
    endfunction

    function automatic mdl_t m_step(input mdl_t s, input cfg_t c,
                                    input bit st, input bit ol, input bit orr, input bit ph);
        mdl_t r;
        int n, m;
        bit who;
        r = s;
        r.brst = 1'b0;
        if (!s.play) begin
            r.spd = 0;
            if (s.fz == 0) begin
                r.play = 1'b1;
                r.spd = c.base;
                r.hits = 0;
            end else begin
                r.brst = (s.fz == 1);
                r.fz = st ? 1 : s.fz - 1;
                if (s.fz == 1 && s.go) begin
                    r.p1 = 0; r.p2 = 0; r.go = 1'b0;
                end
            end
        end else if (ol || orr) begin
            who = !ol;
            n = (who ? s.p2 : s.p1) + 1;
            m = who ? s.p1 : s.p2;
            if (who) r.p2 = n; else r.p1 = n;
            r.sdir = who; r.spd = 0; r.hits = 0; r.play = 1'b0;
            if ((n >= c.win_score && (c.wb2 == 0 || n - m >= 2)) || n == c.cap) begin
                r.go = 1'b1; r.win = who; r.fz = c.over;
            end else begin
                r.fz = c.serve;
            end
        end else if (ph) begin
            r.hits = s.hits + 1;
            if (r.hits == c.hps) begin
                r.hits = 0;
                r.spd = (s.spd + 1 > c.smax) ? c.smax : s.spd + 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= m_reset(cfg_a);
            mb <= m_reset(cfg_b);
        end else begin
            ma <= m_step(ma, cfg_a, ifa.start, ifa.out_left, ifa.out_right, ifa.paddle_hit);
            mb <= m_step(mb, cfg_b, ifb.start, ifb.out_left, ifb.out_right, ifb.paddle_hit);
        end
    end

    // ---------------- accessors and checks ----------------
    function automatic int spd_of(input bit sel); return sel ? int'(ifb.speed) : int'(ifa.speed); endfunction
    function automatic int p1_of(input bit sel);  return sel ? int'(ifb.score_p1) : int'(ifa.score_p1); endfunction
    function automatic int p2_of(input bit sel);  return sel ? int'(ifb.score_p2) : int'(ifa.score_p2); endfunction
    function automatic int br_of(input bit sel);  return sel ? int'(ifb.ball_reset) : int'(ifa.ball_reset); endfunction
    function automatic int sd_of(input bit sel);  return sel ? int'(ifb.serve_dir) : int'(ifa.serve_dir); endfunction
    function automatic int go_of(input bit sel);  return sel ? int'(ifb.game_over) : int'(ifa.game_over); endfunction
    function automatic int win_of(input bit sel); return sel ? int'(ifb.winner) : int'(ifa.winner); endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon_cmp(input bit sel, input mdl_t m);
        n_chk++;
        if (spd_of(sel) != m.spd || br_of(sel) != int'(m.brst) || sd_of(sel) != int'(m.sdir) ||
            p1_of(sel) != m.p1 || p2_of(sel) != m.p2 || go_of(sel) != int'(m.go) ||
            win_of(sel) != int'(m.win)) begin
            n_err++;
            $display("FAIL model_%s t=%0t: got spd=%0d br=%0d sd=%0d p1=%0d p2=%0d go=%0d win=%0d, expected spd=%0d br=%0d sd=%0d p1=%0d p2=%0d go=%0d win=%0d",
                     sel ? "B" : "A", $time, spd_of(sel), br_of(sel), sd_of(sel), p1_of(sel),
                     p2_of(sel), go_of(sel), win_of(sel), m.spd, m.brst, m.sdir, m.p1, m.p2,
                     m.go, m.win);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_cmp(1'b0, ma);
            mon_cmp(1'b1, mb);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input bit sel, input bit st, input bit ol, input bit orr, input bit ph);
        if (!sel) begin
            ifa.start = st; ifa.out_left = ol; ifa.out_right = orr; ifa.paddle_hit = ph;
        end else begin
            ifb.start = st; ifb.out_left = ol; ifb.out_right = orr; ifb.paddle_hit = ph;
        end
    endtask

    // One-cycle pulse; returns at the next falling edge with its effect visible.
    task automatic cyc(input bit sel, input bit st, input bit ol, input bit orr, input bit ph);
        drv(sel, st, ol, orr, ph);
        @(negedge clk);
        drv(sel, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Cut any freeze short with one start pulse and wait for the serve.
    task automatic wait_play(input bit sel);
        int n;
        n = 0;
        if (spd_of(sel) == 0) cyc(sel, 1'b1, 1'b0, 1'b0, 1'b0);
        while (spd_of(sel) == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_play_reached", int'(spd_of(sel) != 0), 1);
    endtask

    task automatic score_pt(input bit sel, input bit right);
        wait_play(sel);
        cyc(sel, 1'b0, !right, right, 1'b0);
    endtask

    // Count frozen samples (speed 0) until the serve, remembering ball_reset on the last one.
    task automatic count_zero(input bit sel, output int n, output int br_last);
        n = 0;
        br_last = 0;
        while (spd_of(sel) == 0 && n < 20000) begin
            br_last = br_of(sel);
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int st; int ol; int orr; int ph; int p1; int p2; int spd; int br; int sd;
    } vec_t;
    vec_t tbl[29];

    initial begin
        #6_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, brl;
        // st ol or ph  p1 p2 spd br sd
        tbl[0]  = '{0,0,0,1, 0,0,11,0,0};
        tbl[1]  = '{0,0,0,1, 0,0,11,0,0};
        tbl[2]  = '{0,0,0,1, 0,0,11,0,0};
        tbl[3]  = '{0,0,0,1, 0,0,12,0,0};
        tbl[4]  = '{0,0,0,1, 0,0,12,0,0};
        tbl[5]  = '{0,0,0,1, 0,0,12,0,0};
        tbl[6]  = '{0,0,0,1, 0,0,12,0,0};
        tbl[7]  = '{0,0,0,1, 0,0,12,0,0};
        tbl[8]  = '{1,0,0,0, 0,0,12,0,0};
        tbl[9]  = '{0,1,1,1, 1,0, 0,0,0};
        tbl[10] = '{0,1,0,0, 1,0, 0,0,0};
        tbl[11] = '{1,0,0,0, 1,0, 0,0,0};
        tbl[12] = '{0,0,0,0, 1,0, 0,1,0};
        tbl[13] = '{0,0,0,0, 1,0,11,0,0};
        tbl[14] = '{0,0,1,1, 1,1, 0,0,1};
        tbl[15] = '{1,0,0,0, 1,1, 0,0,1};
        tbl[16] = '{0,0,0,0, 1,1, 0,1,1};
        tbl[17] = '{0,0,0,0, 1,1,11,0,1};
        tbl[18] = '{0,0,0,1, 1,1,11,0,1};
        tbl[19] = '{0,0,0,1, 1,1,11,0,1};
        tbl[20] = '{0,0,0,1, 1,1,11,0,1};
        tbl[21] = '{0,1,0,0, 2,1, 0,0,0};
        tbl[22] = '{1,0,0,0, 2,1, 0,0,0};
        tbl[23] = '{0,0,0,0, 2,1, 0,1,0};
        tbl[24] = '{0,0,0,0, 2,1,11,0,0};
        tbl[25] = '{0,0,0,1, 2,1,11,0,0};
        tbl[26] = '{0,0,0,1, 2,1,11,0,0};
        tbl[27] = '{0,0,0,1, 2,1,11,0,0};
        tbl[28] = '{0,0,0,1, 2,1,12,0,0};

        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_speed", spd_of(0), 0);
        chk("rst_ball_reset", br_of(0), 1);
        chk("rst_score_p1", p1_of(0), 0);
        chk("rst_score_p2", p2_of(0), 0);
        chk("rst_game_over", go_of(0), 0);
        chk("rst_serve_dir", sd_of(0), 0);
        chk("rst_winner", win_of(0), 0);

        rst_n = 1'b1;
        mon_en = 1'b1;

        // Power-up freeze runs its full length without start.
        count_zero(1'b0, n, brl);
        chk("t1_freeze_len", n, A_OVER + 1);
        chk("t1_ball_reset_last", brl, 1);
        chk("t1_speed_serve", spd_of(0), 11);
        chk("t1_ball_reset_off", br_of(0), 0);

        // Point on the left: p1 credited, serve freeze of SERVE_TICKS.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_p1", p1_of(0), 1);
        chk("t2_speed0", spd_of(0), 0);
        chk("t2_serve_dir", sd_of(0), 0);
        chk("t2_no_ball_reset", br_of(0), 0);
        count_zero(1'b0, n, brl);
        chk("t2_freeze_len", n, A_SERVE + 1);
        chk("t2_ball_reset_last", brl, 1);
        chk("t2_speed_serve", spd_of(0), 11);

        // Start cuts a serve freeze short.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_p2", p2_of(0), 1);
        chk("t3_serve_dir", sd_of(0), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_after_start_speed", spd_of(0), 0);
        chk("t3_after_start_br", br_of(0), 0);
        @(negedge clk);
        chk("t3_pulse_br", br_of(0), 1);
        chk("t3_pulse_speed", spd_of(0), 0);
        @(negedge clk);
        chk("t3_play_speed", spd_of(0), 11);
        chk("t3_play_br", br_of(0), 0);

        // Speed ramp, cap, priority and freeze behaviour on instance B.
        for (int i = 0; i < 29; i++) begin
            cyc(1'b1, tbl[i].st != 0, tbl[i].ol != 0, tbl[i].orr != 0, tbl[i].ph != 0);
            chk($sformatf("vec%0d_p1", i), p1_of(1), tbl[i].p1);
            chk($sformatf("vec%0d_p2", i), p2_of(1), tbl[i].p2);
            chk($sformatf("vec%0d_speed", i), spd_of(1), tbl[i].spd);
            chk($sformatf("vec%0d_ball_reset", i), br_of(1), tbl[i].br);
            chk($sformatf("vec%0d_serve_dir", i), sd_of(1), tbl[i].sd);
        end

        // Win-by-two from 2:1 up to 9:9, then 10:9 (no win), 11:9 (win).
        score_pt(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            score_pt(1'b1, 1'b0);
            score_pt(1'b1, 1'b1);
        end
        chk("t6_9_9_p1", p1_of(1), 9);
        chk("t6_9_9_p2", p2_of(1), 9);
        chk("t6_9_9_go", go_of(1), 0);
        score_pt(1'b1, 1'b0);
        chk("t6_10_9_p1", p1_of(1), 10);
        chk("t6_10_9_go", go_of(1), 0);
        score_pt(1'b1, 1'b0);
        chk("t6_11_9_p1", p1_of(1), 11);
        chk("t6_11_9_go", go_of(1), 1);
        chk("t6_11_9_winner", win_of(1), 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_frozen_no_score", p1_of(1), 11);
        n = 0;
        while (go_of(1) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_over_cleared", go_of(1), 0);
        chk("t6_clear_p1", p1_of(1), 0);
        chk("t6_clear_p2", p2_of(1), 0);

        // Deuce up to 14:14; the ceiling ends the game at 14:15 with a lead of one.
        for (int i = 0; i < 14; i++) begin
            score_pt(1'b1, 1'b0);
            score_pt(1'b1, 1'b1);
        end
        chk("cap_14_14_go", go_of(1), 0);
        score_pt(1'b1, 1'b1);
        chk("cap_p2", p2_of(1), 15);
        chk("cap_go", go_of(1), 1);
        chk("cap_winner", win_of(1), 1);
        chk("cap_serve_dir", sd_of(1), 1);
        wait_play(1'b1);
        chk("cap_next_p1", p1_of(1), 0);
        chk("cap_next_p2", p2_of(1), 0);
        chk("cap_next_go", go_of(1), 0);

        // Plain first-to-nine on A: 8:1 then the winning point.
        for (int i = 0; i < 7; i++) score_pt(1'b0, 1'b0);
        chk("t5_8_p1", p1_of(0), 8);
        chk("t5_8_go", go_of(0), 0);
        score_pt(1'b0, 1'b0);
        chk("t5_9_p1", p1_of(0), 9);
        chk("t5_go", go_of(0), 1);
        chk("t5_winner", win_of(0), 0);
        chk("t5_speed0", spd_of(0), 0);
        n = 0;
        while (go_of(0) != 0 && n < 20000) begin
            if (n == 20) chk("t5_frozen_no_score", p1_of(0), 9);
            ifa.out_left = (n == 10);
            n++;
            @(negedge clk);
        end
        ifa.out_left = 1'b0;
        chk("t5_over_len", n, A_OVER);
        chk("t5_clear_p1", p1_of(0), 0);
        chk("t5_clear_p2", p2_of(0), 0);
        chk("t5_clear_br", br_of(0), 1);
        @(negedge clk);
        chk("t5_next_speed", spd_of(0), 11);

        // Random play on both instances, with an asynchronous reset mid-run.
        for (int i = 0; i < 20000; i++) begin
            drv(1'b0, ($urandom % 40) == 0, ($urandom % 25) == 0, ($urandom % 25) == 0, ($urandom % 3) == 0);
            drv(1'b1, ($urandom % 40) == 0, ($urandom % 25) == 0, ($urandom % 25) == 0, ($urandom % 3) == 0);
            @(negedge clk);
            if (i == 12000) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst_speed", spd_of(0), 0);
                chk("async_rst_br", br_of(0), 1);
                chk("async_rst_p1", p1_of(0), 0);
                chk("async_rst_p2", p2_of(0), 0);
                chk("async_rst_go", go_of(0), 0);
                chk("async_rst_b_speed", spd_of(1), 0);
                chk("async_rst_b_p1", p1_of(1), 0);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
